// File: rtl/popcount_ternary_accum.sv
// Multi-beat ternary neuron: accumulates popcount(pos) - popcount(neg) per frame and thresholds it.
// Optional build macro POPCOUNT_TERNARY_APPROX_LSB_EN rounds each per-beat count down to even.
module popcount_ternary_accum #(
   parameter int  IN_W  = 25,
   parameter int  BEATS = 4,
   localparam int CNT_W = $clog2(IN_W + 1),
   localparam int ACC_W = $clog2(BEATS * IN_W + 1) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_pos,
   input  logic [IN_W-1:0]  in_neg,
   input  logic             in_last,
   input  logic [ACC_W-1:0] thresh,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_fire,
   output logic             out_err
);

   localparam int BCNT_W = $clog2(BEATS + 1);
   localparam logic [BCNT_W-1:0] BEATS_MAX = BCNT_W'(BEATS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   logic [1:0]               state_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [BCNT_W-1:0]        cnt_q;
   logic signed [ACC_W-1:0]  thr_q;
   logic                     out_valid_q;
   logic signed [ACC_W-1:0]  out_sum_q;
   logic                     out_fire_q;
   logic                     out_err_q;

   logic [CNT_W-1:0]         pos_cnt;
   logic [CNT_W-1:0]         neg_cnt;
   logic signed [ACC_W-1:0]  beat_d;
   logic                     first_beat;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  thr_eff;
   logic [BCNT_W-1:0]        cnt_next;
   logic                     frame_end;
   logic                     beat_acc;
   logic                     consume;

   function automatic logic [CNT_W-1:0] popcount(input logic [IN_W-1:0] v);
      logic [CNT_W-1:0] c;
      // NOTE: blocking '=' is correct here: c is a running temporary inside one evaluation.
      c = '0;
      for (int i = 0; i < IN_W; i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

   // A pending result blocks new beats; reset also holds the input side off.
   assign in_ready  = ~rst & ~out_valid_q;
   assign beat_acc  = in_valid & in_ready;
   assign consume   = out_valid_q & out_ready;

   always_comb begin
      // NOTE: every always_comb output gets a value before any branch, so no latch can be inferred.
      pos_cnt = popcount(in_pos);
      neg_cnt = popcount(in_neg);
`ifdef POPCOUNT_TERNARY_APPROX_LSB_EN
      pos_cnt[0] = 1'b0;
      neg_cnt[0] = 1'b0;
`endif
      // Counts are non-negative, so zero-extend before the signed subtraction.
      beat_d     = $signed(ACC_W'(pos_cnt)) - $signed(ACC_W'(neg_cnt));
      first_beat = (state_q == ST_IDLE);
      acc_next   = (first_beat ? '0 : acc_q) + beat_d;
      cnt_next   = (first_beat ? '0 : cnt_q) + BCNT_W'(1);
      thr_eff    = first_beat ? $signed(thresh) : thr_q;
      frame_end  = in_last | (cnt_next == BEATS_MAX);
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         thr_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_fire_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else if (consume) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (beat_acc) begin
         acc_q <= acc_next;
         cnt_q <= cnt_next;
         thr_q <= thr_eff;
         if (frame_end) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            out_sum_q   <= acc_next;
            out_fire_q  <= (acc_next >= thr_eff);
            // Truncation only when the count limit, not in_last, closed the frame.
            out_err_q   <= ~in_last;
         end else begin
            state_q <= ST_ACC;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_fire  = out_fire_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_popcount_ternary_accum.sv
// Scoreboard bench for popcount_ternary_accum: directed scenarios plus randomized frames.
module tb_popcount_ternary_accum;

   localparam int IN_W  = 25;
   localparam int BEATS = 4;
   localparam int ACC_W = 8;
   localparam logic [IN_W-1:0] ALL1 = {IN_W{1'b1}};

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_pos;
   logic [IN_W-1:0]  in_neg;
   logic             in_last;
   logic [ACC_W-1:0] thresh;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             out_fire;
   logic             out_err;

   popcount_ternary_accum #(.IN_W(IN_W), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last), .thresh(thresh),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_fire(out_fire), .out_err(out_err)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: frame-level arithmetic straight from the block's rules.
   typedef struct { int sum; int fire; int err; } exp_t;
   exp_t sb_q[$];
   int m_acc = 0;
   int m_cnt = 0;
   int m_thr = 0;

   function automatic int beat_count(input logic [IN_W-1:0] m);
      int c;
      c = $countones(m);
`ifdef POPCOUNT_TERNARY_APPROX_LSB_EN
      c = c - (c % 2);
`endif
      return c;
   endfunction

   task automatic model_beat(input logic [IN_W-1:0] pos, input logic [IN_W-1:0] neg,
                             input logic last, input int thr);
      exp_t e;
      if (m_cnt == 0) m_thr = thr;
      m_acc = m_acc + beat_count(pos) - beat_count(neg);
      m_cnt++;
      if (last || m_cnt == BEATS) begin
         e.sum  = m_acc;
         e.fire = (m_acc >= m_thr) ? 1 : 0;
         e.err  = last ? 0 : 1;
         sb_q.push_back(e);
         m_acc = 0;
         m_cnt = 0;
      end
   endtask

   task automatic send_beat(input logic [IN_W-1:0] pos, input logic [IN_W-1:0] neg,
                            input logic last, input int thr);
      int w;
      @(negedge clk);
      in_pos   = pos;
      in_neg   = neg;
      in_last  = last;
      thresh   = thr[ACC_W-1:0];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         check("beat_accept_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         model_beat(pos, neg, last, thr);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sb_q.size() != 0 || out_valid) && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("drain_queue_empty", sb_q.size(), 0);
   endtask

   // out_ready policy: 0 = always ready, 1 = random, 2 = stalled.
   int rdy_mode = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops on every consume, and checks that a stalled result holds still.
   logic hold_v = 1'b0;
   int   hold_sum, hold_fire, hold_err;
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_sum",   int'($signed(out_sum)), hold_sum);
            check("hold_fire",  int'(out_fire), hold_fire);
            check("hold_err",   int'(out_err), hold_err);
         end
         if (out_valid) check("in_ready_while_pending", int'(in_ready), 0);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("out_sum",  int'($signed(out_sum)), e.sum);
               check("out_fire", int'(out_fire), e.fire);
               check("out_err",  int'(out_err), e.err);
            end
            hold_v = 1'b0;
         end else if (out_valid) begin
            hold_v    = 1'b1;
            hold_sum  = int'($signed(out_sum));
            hold_fire = int'(out_fire);
            hold_err  = int'(out_err);
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_pos   = '0;
      in_neg   = '0;
      in_last  = 1'b0;
      thresh   = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_sum",   int'(out_sum), 0);
      check("rst_out_fire",  int'(out_fire), 0);
      check("rst_out_err",   int'(out_err), 0);
      @(posedge clk); #3 rst = 1'b0;
      #1 check("release_in_ready", int'(in_ready), 1);

      // Reset mid-frame discards the partial frame.
      send_beat(ALL1, '0, 1'b0, 0);
      send_beat(ALL1, '0, 1'b0, 0);
      @(posedge clk); #3 rst = 1'b1;
      #1;
      check("midrst_in_ready",  int'(in_ready), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_out_sum",   int'(out_sum), 0);
      m_acc = 0;
      m_cnt = 0;
      sb_q.delete();
      @(posedge clk); #3 rst = 1'b0;
      #1 check("midrst_release_in_ready", int'(in_ready), 1);
      send_beat(25'h7, '0, 1'b1, 3);
      drain();

      // Mixed frame at and just above the threshold.
      for (int t = 17; t <= 18; t++) begin
         send_beat(ALL1, '0, 1'b0, t);
         send_beat('0, 25'hFF, 1'b0, 0);
         send_beat(25'h3, 25'h3, 1'b1, 0);
      end
      drain();

      // Negative extreme, last on the final allowed beat.
      for (int i = 0; i < BEATS; i++) send_beat('0, ALL1, 1'(i == BEATS - 1), (i == 0) ? -100 : 99);
      drain();

      // Truncation with the result stalled; a further beat must be held off.
      rdy_mode = 2;
      for (int i = 0; i < BEATS; i++) send_beat(25'h1, '0, 1'b0, 0);
      @(negedge clk);
      check("trunc_latency_out_valid", int'(out_valid), 1);
      in_pos = 25'h1; in_neg = '0; in_last = 1'b1; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("trunc_holdoff_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      rdy_mode = 0;
      send_beat(25'h1, '0, 1'b1, 0);
      drain();

      // Backpressure: five stalled cycles, then single-cycle consume.
      rdy_mode = 2;
      send_beat(25'h1F, 25'h1, 1'b1, 2);
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready",  int'(in_ready), 0);
      end
      rdy_mode = 0;
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      check("bp_consumed", int'(out_valid), 0);
      check("bp_in_ready_after", int'(in_ready), 1);
      drain();

      // Count-rounding cases (odd counts differ between builds).
      send_beat(25'h7, 25'h1, 1'b1, 0);
      send_beat(25'h1F, '0, 1'b1, 0);
      drain();

      // Randomized frames with random backpressure and idle gaps.
      rdy_mode = 1;
      for (int f = 0; f < 150; f++) begin
         int len;
         logic trunc;
         len   = $urandom_range(1, BEATS);
         trunc = (len == BEATS) && ($urandom_range(0, 2) == 0);
         for (int i = 0; i < len; i++) begin
            logic [IN_W-1:0] p, n;
            p = IN_W'($urandom);
            n = IN_W'($urandom);
            case ($urandom_range(0, 3))
               0: p = p & IN_W'($urandom);
               1: n = n & IN_W'($urandom);
               2: begin p = ALL1; n = '0; end
               default: ;
            endcase
            send_beat(p, n, 1'((i == len - 1) && !trunc), int'($urandom_range(0, 200)) - 100);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      rdy_mode = 0;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/popcount_ternary_accum.md
Name: popcount_ternary_accum

Overview:
- Multi-beat ternary neuron core for the printed-NN datapath.
- Each beat applies a positive and a negative input mask of IN_W bits.
- The block accumulates popcount(pos) − popcount(neg) over a frame of up to BEATS beats, then compares the signed sum against a threshold.
- It is the sequential, parametrised successor of the fixed 25-input combinational popcount: it sits between the sensor-word packer and the activation/argmax stage.

Parameters:
- IN_W, 25, bits per beat in each mask.
- BEATS, 4, maximum beats per frame (≥1).
- Derived CNT_W = clog2(IN_W+1), the per-beat count width.
- Derived ACC_W = clog2(BEATS*IN_W+1)+1, the signed accumulator width. Defaults give 5 and 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept
- in_pos  in  IN_W  positive-weight input mask
- in_neg  in  IN_W  negative-weight input mask
- in_last  in  1  final beat of frame
- thresh  in  ACC_W  signed threshold, sampled on first beat
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_sum  out  ACC_W  signed frame sum
- out_fire  out  1  out_sum >= threshold
- out_err  out  1  frame truncated at BEATS without in_last

Behaviour:
- Reset is asynchronous and active-high, and is the one already-decided fact for this block. Asserting rst at any time, including mid-frame or while a result is pending:
  - clears state to IDLE;
  - clears the accumulator, beat counter and latched threshold;
  - drives out_valid=0, out_sum=0, out_fire=0, out_err=0;
  - drives in_ready=0 while rst is high and 1 on the first cycle after release.
- Handshakes:
  - A beat is accepted on a cycle with in_valid & in_ready.
  - A result is consumed on a cycle with out_valid & out_ready.
  - in_ready = ~out_valid, so there is no input acceptance while a result is pending. Throughput is one frame per (beats+1) cycles when out_ready is held high.
- Per beat: d = popcount(in_pos) − popcount(in_neg), exact and sign-extended to ACC_W. A bit set in both masks counts +1 and −1, giving 0 net.
- States:
  - IDLE: no beat in progress, acc=0. An accepted beat sets acc=d, latches thresh, sets cnt=1 and goes to ACC. If that beat also ends the frame, go directly to OUT.
  - ACC: each accepted beat does acc+=d and cnt+=1. The frame ends when in_last=1 or cnt reaches BEATS. Idle cycles with in_valid=0 hold state.
  - OUT: out_valid=1. out_sum, out_fire and out_err are registered and stable until consumed. On consume, go to IDLE and clear acc and cnt. The cycle after consume, in_ready=1.
- Frame-end timing: out_valid rises the cycle after the frame's last beat is accepted (latency 1). out_sum includes that beat.
- out_fire = ($signed(out_sum) >= $signed(thresh_latched)). The thresh port is ignored except on a frame's first beat.
- out_err = 1 iff the frame ended because cnt hit BEATS while in_last=0. in_last=1 on beat BEATS gives out_err=0.
- Overflow is impossible by construction: |sum| ≤ BEATS*IN_W fits in signed ACC_W. No saturation logic.
- All outputs are registered. There is no combinational path from in_* to out_*.

Optional Feature:
- Macro: POPCOUNT_TERNARY_APPROX_LSB_EN.
- When defined, each per-beat popcount has its LSB forced to 0 before subtraction, i.e. it is rounded down to even. This is a cheaper counter tree matching the approximate-popcount library style. Frame error is at most BEATS per polarity.
- When undefined, counts are exact.
- Handshake, latency and out_err are identical in both builds.

Test Plan:
- Reset mid-frame: accept 2 beats (pos=0x1FFFFFF), assert rst, then send 1 beat pos=0x7 neg=0 last=1 thresh=3 -> out_sum=3, out_fire=1, out_err=0 (exact build).
- Mixed frame: beats (pos=0x1FFFFFF, neg=0), (pos=0, neg=0xFF), (pos=0x3, neg=0x3, last=1), thresh=17 -> out_sum=17, out_fire=1. Same frame with thresh=18 -> out_fire=0.
- Negative extreme: 4 beats pos=0 neg=0x1FFFFFF, last on 4th, thresh=-100 -> out_sum=-100, out_fire=1, out_err=0.
- Truncation: 4 beats pos=0x1 with in_last=0 throughout -> out_valid after 4th beat, out_sum=4, out_err=1. A 5th beat is held off (in_ready=0) until consumed.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_sum, out_fire and out_err stable and in_ready=0. On out_ready=1, consume happens in 1 cycle and in_ready=1 the next cycle.
- Approx build: single beat pos=0x7 (3) neg=0x1 (1) last=1 -> out_sum=2 with the macro, 2 without. Beat pos=0x1F (5) neg=0 -> 4 with the macro, 5 without.
